// File: rtl/aes128_type_pkg.sv
// ----------------------------------------------------------------------------
// aes128_type_pkg
// Shared types and constants for the AES128 byte-serial datapath.
//   AES128_N_BYTES : bytes per AES state
//   COL_*          : byte-collector FSM state encodings
//   err_code_e     : collector error causes reported on err_code_o
// ----------------------------------------------------------------------------
package aes128_type_pkg;

    localparam int unsigned AES128_N_BYTES = 16;

    // Collector FSM states
    localparam logic [1:0] COL_IDLE    = 2'd0;
    localparam logic [1:0] COL_COLLECT = 2'd1;
    localparam logic [1:0] COL_DONE    = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_DUP        = 2'd1,
        ERR_EARLY_DONE = 2'd2,
        ERR_ORDER      = 2'd3
    } err_code_e;

endpackage

// File: rtl/aes128_byte_collector.sv
// ----------------------------------------------------------------------------
// aes128_byte_collector
// Receiving end of the byte-serial sub-bytes stream. Captures indexed bytes
// into a registered N_BYTES-byte state, tracks which indices have arrived and
// reports completion or protocol errors.
//
// Optional build macro: AES128_COLLECT_INORDER_CHECK_EN
//   defined   : beats must arrive with addr_i equal to the running expected
//               index, otherwise err_code_o = 3 (byte still written)
//   undefined : any index permutation completes
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   start_i     in   arm/restart the collector (clears mask and errors)
//   data_i      in   byte value
//   addr_i      in   byte index of data_i
//   valid_i     in   data_i/addr_i qualify this cycle
//   done_i      in   producer end-of-burst pulse
//   state_o     out  collected state, byte k at state_o[k]
//   busy_o      out  high while collecting
//   complete_o  out  one-cycle pulse: all bytes received without error
//   err_o       out  sticky protocol error
//   err_code_o  out  cause of first error (0 none, 1 dup, 2 early done, 3 order)
// ----------------------------------------------------------------------------
module aes128_byte_collector
    import aes128_type_pkg::*;
#(
    parameter int unsigned N_BYTES = AES128_N_BYTES
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [7:0]                   data_i,
    input  logic [$clog2(N_BYTES)-1:0]   addr_i,
    input  logic                         valid_i,
    input  logic                         done_i,
    output logic [N_BYTES-1:0][7:0]      state_o,
    output logic                         busy_o,
    output logic                         complete_o,
    output logic                         err_o,
    output logic [1:0]                   err_code_o
);

    localparam int unsigned AW = $clog2(N_BYTES);
    localparam logic [AW:0] N_EXT = (AW+1)'(N_BYTES);

    logic [1:0]              fsm_q,   fsm_d;
    logic [N_BYTES-1:0][7:0] state_q, state_d;
    logic [N_BYTES-1:0]      mask_q,  mask_d;
    logic                    err_q,   err_d;
    err_code_e               code_q,  code_d;

`ifdef AES128_COLLECT_INORDER_CHECK_EN
    localparam logic [AW-1:0] LAST_IDX = AW'(N_BYTES - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    logic [AW-1:0]           exp_q,   exp_d;
`endif

    logic                    in_range;
    logic [N_BYTES-1:0]      onehot;
    logic [N_BYTES-1:0]      mask_next;
    logic                    mask_full;
    logic                    beat_err;
    err_code_e               beat_code;

    // Index range guard only matters for non-power-of-2 N_BYTES.
    assign in_range = ({1'b0, addr_i} < N_EXT);

    always_comb begin
        onehot = '0;
        if (in_range) begin
            onehot[addr_i] = 1'b1;
        end
        mask_next = mask_q | (valid_i ? onehot : '0);
        mask_full = &mask_next;
    end

    // Error raised by the current beat; duplicate takes precedence over order.
    always_comb begin
        beat_err  = 1'b0;
        beat_code = ERR_NONE;
        if (valid_i && in_range && mask_q[addr_i]) begin
            beat_err  = 1'b1;
            beat_code = ERR_DUP;
        end
`ifdef AES128_COLLECT_INORDER_CHECK_EN
        else if (valid_i && in_range && (addr_i != exp_q)) begin
            beat_err  = 1'b1;
            beat_code = ERR_ORDER;
        end
        else if (valid_i && !in_range) begin
            beat_err  = 1'b1;
            beat_code = ERR_ORDER;
        end
`endif
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        mask_d  = mask_q;
        err_d   = err_q;
        code_d  = code_q;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
        exp_d   = exp_q;
`endif
        case (fsm_q)
            COL_IDLE: begin
                if (start_i) begin
                    fsm_d  = COL_COLLECT;
                    mask_d = '0;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
                    exp_d  = '0;
`endif
                end
            end

            COL_COLLECT: begin
                if (start_i) begin
                    // Restart wins; any coincident beat is dropped.
                    mask_d = '0;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
                    exp_d  = '0;
`endif
                end else begin
                    if (valid_i && in_range) begin
                        state_d[addr_i] = data_i;
                        mask_d          = mask_next;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
                        exp_d = (exp_q == LAST_IDX) ? '0 : exp_q + IDX_ONE;
`endif
                    end
                    if (beat_err) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            code_d = beat_code;
                        end
                    end
                    // Full mask completes regardless of done_i.
                    if (mask_full) begin
                        fsm_d = COL_DONE;
                    end else if (done_i) begin
                        fsm_d = COL_IDLE;
                        err_d = 1'b1;
                        if (!err_q && !beat_err) begin
                            code_d = ERR_EARLY_DONE;
                        end
                    end
                end
            end

            COL_DONE: begin
                if (start_i) begin
                    fsm_d  = COL_COLLECT;
                    mask_d = '0;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
                    exp_d  = '0;
`endif
                end else begin
                    fsm_d = COL_IDLE;
                end
            end

            default: begin
                fsm_d = COL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= COL_IDLE;
            state_q <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
            exp_q   <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            code_q  <= code_d;
`ifdef AES128_COLLECT_INORDER_CHECK_EN
            exp_q   <= exp_d;
`endif
        end
    end

    assign state_o    = state_q;
    assign busy_o     = (fsm_q == COL_COLLECT);
    // err_q already includes any error raised by the completing beat.
    assign complete_o = (fsm_q == COL_DONE) && !err_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_aes128_byte_collector.sv
// ----------------------------------------------------------------------------
// tb_aes128_byte_collector
// Scoreboard bench for aes128_byte_collector. Each burst's expected outcome
// is computed from the beat list and pushed into a queue; a monitor pops it
// whenever the collector leaves COLLECT (busy_o falls) and compares outcome
// flags and the collected state.
// Honours AES128_COLLECT_INORDER_CHECK_EN when computing expectations.
// ----------------------------------------------------------------------------
module tb_aes128_byte_collector;

`ifdef AES128_COLLECT_INORDER_CHECK_EN
    localparam bit INORDER = 1'b1;
`else
    localparam bit INORDER = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        data_i = '0;
    logic [3:0]        addr_i = '0;
    logic              valid_i = 1'b0;
    logic              done_i = 1'b0;
    logic [15:0][7:0]  state_o;
    logic              busy_o;
    logic              complete_o;
    logic              err_o;
    logic [1:0]        err_code_o;

    aes128_byte_collector #(.N_BYTES(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .data_i     (data_i),
        .addr_i     (addr_i),
        .valid_i    (valid_i),
        .done_i     (done_i),
        .state_o    (state_o),
        .busy_o     (busy_o),
        .complete_o (complete_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             comp;
        logic             err;
        logic [1:0]       code;
        logic [15:0][7:0] st;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  m_st [16];
    int          b_addr[$];
    logic [7:0]  b_data[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0][7:0] model_state();
        logic [15:0][7:0] s;
        for (int k = 0; k < 16; k++) s[k] = m_st[k];
        return s;
    endfunction

    // Outcome of the beat list b_addr/b_data from the protocol rules: bytes
    // land at their index, first error wins, a full set of indices completes,
    // the final beat carries done.
    function automatic exp_t model_burst();
        exp_t e;
        bit   seen [16];
        int   nseen = 0;
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        e = '0;
        for (int i = 0; i < b_addr.size(); i++) begin
            int         a = b_addr[i];
            logic [1:0] c = 2'd0;
            if (seen[a])                    c = 2'd1;
            else if (INORDER && a != i % 16) c = 2'd3;
            if (c != 2'd0 && !e.err) begin
                e.err  = 1'b1;
                e.code = c;
            end
            m_st[a] = b_data[i];
            if (!seen[a]) begin
                seen[a] = 1'b1;
                nseen++;
            end
            if (nseen == 16) begin
                e.comp = !e.err;
                break;
            end
            if (i == b_addr.size() - 1) begin
                if (!e.err) e.code = 2'd2;
                e.err = 1'b1;
            end
        end
        e.st = model_state();
        return e;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        rst_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; done_i = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start_i = 1'b1; valid_i = 1'b0; done_i = 1'b0;
    endtask

    task automatic beat(input int a, input logic [7:0] d, input logic dn);
        @(posedge clk); #1;
        start_i = 1'b0; valid_i = 1'b1; addr_i = 4'(a); data_i = d; done_i = dn;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_burst(input bit with_start);
        sb_q.push_back(model_burst());
        if (with_start) do_start();
        for (int i = 0; i < b_addr.size(); i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            beat(b_addr[i], b_data[i], i == b_addr.size() - 1);
        end
        idle_cycle();
        drain();
    endtask

    // Monitor: one scoreboard entry per exit from COLLECT.
    initial begin
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_end", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("complete", complete_o, e.comp);
                    chk("err", err_o, e.err);
                    chk("err_code", err_code_o, e.code);
                    chk("state", state_o, e.st);
                end
            end else if (complete_o) begin
                chk("spurious_complete", complete_o, 1'b0);
            end
            prev_busy = busy_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p [16];
        int pos, tmp, j, kind, n;

        for (int k = 0; k < 16; k++) m_st[k] = 8'h00;
        repeat (2) @(posedge clk);
        idle_cycle();
        @(negedge clk);
        chk("rst_state", state_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_code", err_code_o, 2'd0);
        chk("rst_complete", complete_o, 1'b0);

        // In-order burst, data 0x63+k
        b_addr.delete(); b_data.delete();
        for (int k = 0; k < 16; k++) begin b_addr.push_back(k); b_data.push_back(8'(8'h63 + k)); end
        run_burst(1'b1);

        // Reverse order
        b_addr.delete(); b_data.delete();
        for (int k = 15; k >= 0; k--) begin b_addr.push_back(k); b_data.push_back(8'($urandom)); end
        run_burst(1'b1);

        // Duplicate index 5 (0x11 then 0x22)
        b_addr.delete(); b_data.delete();
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin
                b_addr.push_back(5); b_data.push_back(8'h11);
                b_addr.push_back(5); b_data.push_back(8'h22);
            end else begin
                b_addr.push_back(k); b_data.push_back(8'($urandom));
            end
        end
        run_burst(1'b1);
        chk("dup_byte5", state_o[5], 8'h22);

        // Early done after 10 beats, then beats in IDLE must be ignored
        b_addr.delete(); b_data.delete();
        for (int k = 0; k < 10; k++) begin b_addr.push_back(k); b_data.push_back(8'($urandom)); end
        run_burst(1'b1);
        for (int k = 0; k < 3; k++) beat(k, 8'hA5, k == 2);
        idle_cycle();
        @(negedge clk);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_state", state_o, model_state());

        // Burst interrupted by start_i coincident with beat 7
        do_start();
        for (int k = 0; k < 7; k++) begin
            logic [7:0] d = 8'($urandom);
            beat(k, d, 1'b0);
            m_st[k] = d;
        end
        @(posedge clk); #1;
        start_i = 1'b1; valid_i = 1'b1; addr_i = 4'd7; data_i = 8'hEE; done_i = 1'b0;
        idle_cycle();
        @(negedge clk);
        chk("restart_drop7", state_o[7], m_st[7]);
        chk("restart_busy", busy_o, 1'b1);
        b_addr.delete(); b_data.delete();
        for (int k = 0; k < 16; k++) begin b_addr.push_back(k); b_data.push_back(8'($urandom)); end
        run_burst(1'b0);

        // Randomised bursts: permutations, injected duplicates, early done
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 16; k++) p[k] = k;
            for (int k = 15; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = p[k]; p[k] = p[j]; p[j] = tmp;
            end
            b_addr.delete(); b_data.delete();
            kind = $urandom_range(0, 2);
            n = (kind == 2) ? $urandom_range(1, 15) : 16;
            for (int k = 0; k < n; k++) begin b_addr.push_back(p[k]); b_data.push_back(8'($urandom)); end
            if (kind == 1) begin
                pos = $urandom_range(1, 15);
                b_addr.insert(pos, b_addr[$urandom_range(0, pos - 1)]);
                b_data.insert(pos, 8'($urandom));
            end
            run_burst(1'b1);
        end

        // Reset mid-burst
        do_start();
        for (int k = 0; k < 5; k++) beat(k, 8'($urandom), 1'b0);
        for (int k = 0; k < 16; k++) m_st[k] = 8'h00;
        sb_q.push_back(exp_t'{comp: 1'b0, err: 1'b0, code: 2'd0, st: '0});
        @(posedge clk); #1;
        rst_i = 1'b1; valid_i = 1'b1; addr_i = 4'd5; data_i = 8'h5A;
        idle_cycle();
        @(negedge clk);
        chk("midrst_state", state_o, '0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_err", err_o, 1'b0);
        chk("midrst_complete", complete_o, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
